// File: rtl/myminimac_pkg.sv
// -----------------------------------------------------------------------------
// myminimac_pkg
//
// Shared definitions for the myminimac Ethernet MAC datapath:
//   - reflected CRC-32 constants and a byte-wide update function
//   - RMII preamble / SFD dibit values
//   - RMII receive state encoding
//   - rx_err_code values reported with rx_eof
// -----------------------------------------------------------------------------
package myminimac_pkg;

  // Reflected (LSB-first) Ethernet CRC-32.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  // Register value left behind after the FCS itself has been run through
  // the CRC. Seeing it means the frame is intact.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  // Dibits as they appear on RXD[1:0]. 0x55 gives 01,01,01,01 and
  // 0xD5 gives 01,01,01,11, so the SFD is detected on its last dibit.
  localparam logic [1:0] RMII_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] RMII_SFD_DIBIT      = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_PREAMBLE = 3'd1,
    RX_DATA     = 3'd2,
    RX_DROP     = 3'd3,
    RX_END      = 3'd4
  } rx_state_e;

  // rx_err_code values, listed from lowest to highest priority.
  localparam logic [1:0] RX_ERR_NONE  = 2'd0;
  localparam logic [1:0] RX_ERR_CRC   = 2'd1;
  localparam logic [1:0] RX_ERR_LEN   = 2'd2;
  localparam logic [1:0] RX_ERR_ALIGN = 2'd3;

  // One byte of reflected CRC-32. Bit 0 of the data goes in first, which
  // matches the order the bits travel on the wire.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/myminimac_crc32_d8.sv
// -----------------------------------------------------------------------------
// myminimac_crc32_d8
//
// Combinational, byte-wide update of a reflected CRC-32. The TX path uses
// this same block.
//
// Ports:
//   crc_i   [31:0]  current CRC register
//   data_i  [7:0]   byte to fold in, bit 0 first
//   crc_o   [31:0]  CRC after the byte
// -----------------------------------------------------------------------------
module myminimac_crc32_d8
  import myminimac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_d8(crc_i, data_i);

endmodule

// File: rtl/myminimac_rmii_rx.sv
// -----------------------------------------------------------------------------
// myminimac_rmii_rx
//
// RMII receive front end. It strips the preamble and SFD from the RMII dibit
// stream, assembles bytes LSB-dibit first, and checks FCS, length and
// alignment. The output is a byte stream with an SOF marker and an
// end-of-frame status pulse. Everything runs in the 50 MHz RMII clock
// domain.
//
// Ports:
//   phy_rmii_clk          50 MHz RMII reference clock
//   sys_rst               asynchronous, active-high reset
//   phy_rmii_crs          RMII CRS_DV
//   phy_rmii_rx_data[1:0] RMII RXD
//   speed_10              1 = 10 Mb/s (each dibit held 10 clocks), 0 = 100 Mb/s
//   rx_valid              one-cycle byte strobe
//   rx_data[7:0]          received byte (DA first, FCS included); holds
//   rx_sof                qualifies rx_valid on the first byte after the SFD
//   rx_eof                one-cycle end-of-frame pulse, never with rx_valid
//   rx_err                frame bad; valid with rx_eof, holds
//   rx_err_code[1:0]      0 none, 1 CRC, 2 length, 3 alignment; holds
//   rx_len[10:0]          byte count incl. FCS, saturates at MAX_FRAME+1
// -----------------------------------------------------------------------------
module myminimac_rmii_rx
  import myminimac_pkg::*;
#(
  parameter int MAX_FRAME = 1536,
  parameter int MIN_FRAME = 64
) (
  input  logic        phy_rmii_clk,
  input  logic        sys_rst,
  input  logic        phy_rmii_crs,
  input  logic [1:0]  phy_rmii_rx_data,
  input  logic        speed_10,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [1:0]  rx_err_code,
  output logic [10:0] rx_len
);

  localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [3:0]  DIV_LAST = 4'd9;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e   state_q,     state_d;
  logic [3:0]  div_q,       div_d;        // 10 Mb/s sample divider
  logic [1:0]  dibit_cnt_q, dibit_cnt_d;  // dibits of the current byte
  logic [5:0]  shift_q,     shift_d;      // first three dibits of the byte
  logic [31:0] crc_q,       crc_d;
  logic [10:0] len_q,       len_d;
  logic        sof_pend_q,  sof_pend_d;   // next byte is the first one
  logic        align_err_q, align_err_d;
  logic        len_err_q,   len_err_d;

  logic        rx_valid_q,    rx_valid_d;
  logic [7:0]  rx_data_q,     rx_data_d;
  logic        rx_sof_q,      rx_sof_d;
  logic        rx_eof_q,      rx_eof_d;
  logic        rx_err_q,      rx_err_d;
  logic [1:0]  rx_err_code_q, rx_err_code_d;
  logic [10:0] rx_len_q,      rx_len_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic        sample_en;
  logic [7:0]  rx_byte;
  logic [31:0] crc_next;
  logic [10:0] len_inc;
  logic [1:0]  end_code;

  // At 100 Mb/s every clock carries a dibit. At 10 Mb/s only divider
  // count 0 does. The divider stays at 0 while idle, so the first CRS_DV
  // high sample lines the divider up with the start of the PHY's dibit.
  assign sample_en = !speed_10 || (div_q == 4'd0);

  // The dibit on the pins now is d3, the newest dibit of the byte.
  assign rx_byte = {phy_rmii_rx_data, shift_q};
  assign len_inc = len_q + 11'd1;

  myminimac_crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (rx_byte),
    .crc_o  (crc_next)
  );

  // Status reported at END. Priority is alignment, then length, then CRC.
  always_comb begin
    if (align_err_q)
      end_code = RX_ERR_ALIGN;
    else if (len_err_q || (len_q < MIN_LEN) || (len_q > MAX_LEN))
      end_code = RX_ERR_LEN;
    else if (crc_q != CRC32_RESIDUE)
      end_code = RX_ERR_CRC;
    else
      end_code = RX_ERR_NONE;
  end

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!speed_10 || ((state_q == RX_IDLE) && !phy_rmii_crs))
      div_d = 4'd0;
    else if (div_q == DIV_LAST)
      div_d = 4'd0;
    else
      div_d = div_q + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path
    // through this block leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    dibit_cnt_d   = dibit_cnt_q;
    shift_d       = shift_q;
    crc_d         = crc_q;
    len_d         = len_q;
    sof_pend_d    = sof_pend_q;
    align_err_d   = align_err_q;
    len_err_d     = len_err_q;

    rx_valid_d    = 1'b0;
    rx_sof_d      = 1'b0;
    rx_eof_d      = 1'b0;
    rx_data_d     = rx_data_q;
    rx_err_d      = rx_err_q;
    rx_err_code_d = rx_err_code_q;
    rx_len_d      = rx_len_q;

    unique case (state_q)
      RX_IDLE: begin
        // Hold the per-frame state clean for as long as the line is idle.
        crc_d       = CRC32_INIT;
        len_d       = '0;
        sof_pend_d  = 1'b1;
        align_err_d = 1'b0;
        len_err_d   = 1'b0;
        dibit_cnt_d = '0;
        if (sample_en && phy_rmii_crs && (phy_rmii_rx_data == RMII_PREAMBLE_DIBIT))
          state_d = RX_PREAMBLE;
      end

      RX_PREAMBLE: begin
        if (sample_en) begin
          if (!phy_rmii_crs)
            state_d = RX_IDLE;
          else if (phy_rmii_rx_data == RMII_SFD_DIBIT) begin
            state_d     = RX_DATA;
            dibit_cnt_d = '0;
          end else if (phy_rmii_rx_data != RMII_PREAMBLE_DIBIT)
            state_d = RX_DROP;
        end
      end

      RX_DATA: begin
        if (sample_en) begin
          if (!phy_rmii_crs) begin
            // A carrier drop on a byte boundary is the normal end of a
            // frame. Anywhere else, the frame held a partial byte.
            state_d = RX_END;
            if (dibit_cnt_q != 2'd0)
              align_err_d = 1'b1;
          end else begin
            shift_d     = {phy_rmii_rx_data, shift_q[5:2]};
            dibit_cnt_d = dibit_cnt_q + 2'd1;
            if (dibit_cnt_q == 2'd3) begin
              crc_d = crc_next;
              len_d = len_inc;
              if (len_inc > MAX_LEN) begin
                // The byte counter stops here, so rx_len saturates at
                // MAX_FRAME+1.
                len_err_d = 1'b1;
                state_d   = RX_DROP;
              end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_byte;
                rx_sof_d   = sof_pend_q;
                sof_pend_d = 1'b0;
              end
            end
          end
        end
      end

      RX_DROP: begin
        // An oversize frame still gets reported. A bad preamble does not.
        if (sample_en && !phy_rmii_crs)
          state_d = len_err_q ? RX_END : RX_IDLE;
      end

      RX_END: begin
        rx_eof_d      = 1'b1;
        rx_err_code_d = end_code;
        rx_err_d      = (end_code != RX_ERR_NONE);
        rx_len_d      = len_q;
        crc_d         = CRC32_INIT;
        len_d         = '0;
        sof_pend_d    = 1'b1;
        align_err_d   = 1'b0;
        len_err_d     = 1'b0;
        state_d       = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge phy_rmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= RX_IDLE;
      div_q         <= '0;
      dibit_cnt_q   <= '0;
      shift_q       <= '0;
      crc_q         <= CRC32_INIT;
      len_q         <= '0;
      sof_pend_q    <= 1'b1;
      align_err_q   <= 1'b0;
      len_err_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_sof_q      <= 1'b0;
      rx_eof_q      <= 1'b0;
      rx_err_q      <= 1'b0;
      rx_err_code_q <= '0;
      rx_len_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // values from before this edge, whatever order the lines are in.
      state_q       <= state_d;
      div_q         <= div_d;
      dibit_cnt_q   <= dibit_cnt_d;
      shift_q       <= shift_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      sof_pend_q    <= sof_pend_d;
      align_err_q   <= align_err_d;
      len_err_q     <= len_err_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      rx_sof_q      <= rx_sof_d;
      rx_eof_q      <= rx_eof_d;
      rx_err_q      <= rx_err_d;
      rx_err_code_q <= rx_err_code_d;
      rx_len_q      <= rx_len_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_sof      = rx_sof_q;
  assign rx_eof      = rx_eof_q;
  assign rx_err      = rx_err_q;
  assign rx_err_code = rx_err_code_q;
  assign rx_len      = rx_len_q;

endmodule

// File: tb/tb_myminimac_rmii_rx.sv
// -----------------------------------------------------------------------------
// tb_myminimac_rmii_rx
//
// Directed bench for the RMII receive front end. Frames are built as byte
// queues, given a bench-computed FCS, and driven as LSB-first dibits on the
// falling clock edge. A monitor collects rx_valid bytes and rx_eof status on
// the falling edge. Expected counts, codes and lengths are hand-derived
// from the frame sizes and the injected defect.
// -----------------------------------------------------------------------------
module tb_myminimac_rmii_rx;

  logic        phy_rmii_clk = 1'b0;
  logic        sys_rst      = 1'b1;
  logic        phy_rmii_crs = 1'b0;
  logic [1:0]  phy_rmii_rx_data = 2'b00;
  logic        speed_10     = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [1:0]  rx_err_code;
  logic [10:0] rx_len;

  myminimac_rmii_rx #(.MAX_FRAME(1536), .MIN_FRAME(64)) dut (
    .phy_rmii_clk     (phy_rmii_clk),
    .sys_rst          (sys_rst),
    .phy_rmii_crs     (phy_rmii_crs),
    .phy_rmii_rx_data (phy_rmii_rx_data),
    .speed_10         (speed_10),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_sof           (rx_sof),
    .rx_eof           (rx_eof),
    .rx_err           (rx_err),
    .rx_err_code      (rx_err_code),
    .rx_len           (rx_len)
  );

  always #10 phy_rmii_clk = ~phy_rmii_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  logic [7:0]  got[$];
  bit          sofs[$];
  int          vt[$];
  int          eof_cnt = 0;
  int          overlap = 0;
  logic        eof_err;
  logic [1:0]  eof_code;
  logic [10:0] eof_len;

  always @(posedge phy_rmii_clk) cyc++;

  always @(negedge phy_rmii_clk) begin
    if (!sys_rst) begin
      if (rx_valid) begin
        got.push_back(rx_data);
        sofs.push_back(rx_sof);
        vt.push_back(cyc);
      end
      if (rx_eof) begin
        eof_cnt++;
        eof_err  = rx_err;
        eof_code = rx_err_code;
        eof_len  = rx_len;
        if (rx_valid) overlap++;
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    sofs.delete();
    vt.delete();
    eof_cnt = 0;
    overlap = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Frame construction (reference CRC-32, reflected, FCS appended LSB first)
  // ---------------------------------------------------------------------------
  logic [7:0] frm[$];

  function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++)
      c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  task automatic make_frame(input int n_payload);
    logic [31:0] c;
    logic [31:0] fcs;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_payload; i++) begin
      frm.push_back(8'((i * 37 + 11) & 255));
      c = ref_crc(c, frm[i]);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_dibit(input logic [1:0] d, input int hold);
    phy_rmii_crs     = 1'b1;
    phy_rmii_rx_data = d;
    repeat (hold) @(negedge phy_rmii_clk);
  endtask

  task automatic drive_byte(input logic [7:0] b, input int hold);
    for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2], hold);
  endtask

  // rst_at >= 0 asserts sys_rst in place of frame byte rst_at and abandons
  // the frame.
  task automatic send_frame(input int hold, input bit bad_pre, input bit extra, input int rst_at);
    logic [7:0] pb;
    for (int p = 0; p < 8; p++) begin
      if (p == 7)                  pb = 8'hD5;
      else if (bad_pre && p == 2)  pb = 8'h59;  // dibits 01,10,01,01
      else                         pb = 8'h55;
      drive_byte(pb, hold);
    end
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        #5;
        sys_rst          = 1'b1;
        phy_rmii_crs     = 1'b0;
        phy_rmii_rx_data = 2'b00;
        #1;
        check("t6_rst_outputs_zero",
              {rx_valid, rx_data, rx_sof, rx_eof, rx_err, rx_err_code, rx_len}, 0);
        repeat (3) @(negedge phy_rmii_clk);
        sys_rst = 1'b0;
        repeat (20) @(negedge phy_rmii_clk);
        return;
      end
      drive_byte(frm[i], hold);
    end
    if (extra) drive_dibit(2'b00, hold);
    phy_rmii_crs     = 1'b0;
    phy_rmii_rx_data = 2'b00;
    repeat (20 * hold) @(negedge phy_rmii_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level comparison against frm[]
  // ---------------------------------------------------------------------------
  task automatic check_frame(input string t, input int exp_n, input logic [1:0] exp_code,
                             input int exp_len, input int exp_gap);
    int mism    = 0;
    int sof_bad = 0;
    int gap_bad = 0;
    check({t, "_nbytes"}, got.size(), exp_n);
    for (int i = 0; i < got.size() && i < frm.size(); i++) begin
      if (got[i] !== frm[i]) mism++;
      if (sofs[i] != (i == 0)) sof_bad++;
      if (i > 0 && (vt[i] - vt[i-1]) != exp_gap) gap_bad++;
    end
    check({t, "_data_mismatches"}, mism, 0);
    check({t, "_sof_misplaced"}, sof_bad, 0);
    check({t, "_strobe_spacing_bad"}, gap_bad, 0);
    check({t, "_eof_count"}, eof_cnt, 1);
    check({t, "_eof_err"}, {31'd0, eof_err}, {31'd0, exp_code != 2'd0});
    check({t, "_eof_code"}, {30'd0, eof_code}, {30'd0, exp_code});
    check({t, "_eof_len"}, {21'd0, eof_len}, exp_len);
    check({t, "_eof_with_valid"}, overlap, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (3) @(negedge phy_rmii_clk);
    check("t0_outputs_in_reset",
          {rx_valid, rx_data, rx_sof, rx_eof, rx_err, rx_err_code, rx_len}, 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge phy_rmii_clk);
    check("t0_outputs_after_reset",
          {rx_valid, rx_data, rx_sof, rx_eof, rx_err, rx_err_code, rx_len}, 0);

    // 1: good 64-byte frame at 100 Mb/s
    clear_mon();
    make_frame(60);
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("t1_good", 64, 2'd0, 64, 4);

    // 2: payload byte 10 bit 0 flipped after FCS -> CRC error
    clear_mon();
    make_frame(60);
    frm[10] = frm[10] ^ 8'h01;
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("t2_crc", 64, 2'd1, 64, 4);

    // 3a: 40-byte frame (runt) with good FCS
    clear_mon();
    make_frame(36);
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("t3_runt", 40, 2'd2, 40, 4);

    // 3b: 1600-byte frame -> 1536 bytes delivered, length saturates at 1537
    clear_mon();
    make_frame(1596);
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("t3_giant", 1536, 2'd2, 1537, 4);

    // 4a: good frame plus one extra dibit -> alignment error
    clear_mon();
    make_frame(60);
    send_frame(1, 1'b0, 1'b1, -1);
    check_frame("t4_align", 64, 2'd3, 64, 4);

    // 4b: preamble containing 2'b10 -> frame silently dropped
    clear_mon();
    make_frame(60);
    send_frame(1, 1'b1, 1'b0, -1);
    check("t4_badpre_nbytes", got.size(), 0);
    check("t4_badpre_eof_count", eof_cnt, 0);

    // 5: 10 Mb/s, every dibit held 10 clocks
    speed_10 = 1'b1;
    repeat (4) @(negedge phy_rmii_clk);
    clear_mon();
    make_frame(60);
    send_frame(10, 1'b0, 1'b0, -1);
    check_frame("t5_10m", 64, 2'd0, 64, 40);
    speed_10 = 1'b0;
    repeat (4) @(negedge phy_rmii_clk);

    // 6: reset in place of byte 20, then a clean frame
    clear_mon();
    make_frame(60);
    send_frame(1, 1'b0, 1'b0, 20);
    check("t6_bytes_before_rst", got.size(), 20);
    check("t6_no_eof_after_rst", eof_cnt, 0);
    clear_mon();
    make_frame(60);
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("t6_after_rst", 64, 2'd0, 64, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/myminimac_rmii_rx.md
Name: myminimac_rmii_rx

Overview:
RMII receive front end for the myminimac Ethernet MAC. It takes the raw RMII dibit stream from the PHY (or from the TX serializer in loopback), strips the preamble and SFD, and assembles bytes. It checks FCS, length and alignment, and presents a byte stream with frame delimiters and status to the MAC RX slot/DMA logic downstream.
Runs entirely in the RMII 50 MHz domain; the CDC to sys_clk is handled downstream.

Parameters:
MAX_FRAME, 1536, maximum accepted frame length in bytes (DA..FCS inclusive)
MIN_FRAME, 64, minimum accepted frame length in bytes (DA..FCS inclusive)

Ports:
phy_rmii_clk  in  1  50 MHz RMII reference clock; the only clock
sys_rst  in  1  asynchronous, active-high reset
phy_rmii_crs  in  1  RMII CRS_DV
phy_rmii_rx_data  in  2  RMII RXD[1:0]
speed_10  in  1  1 = 10 Mb/s mode (each dibit held 10 clocks); 0 = 100 Mb/s; static during a frame
rx_valid  out  1  one-cycle strobe: rx_data holds a frame byte
rx_data  out  8  received byte; DA first, FCS included
rx_sof  out  1  asserted together with rx_valid on the first byte after SFD
rx_eof  out  1  one-cycle end-of-frame pulse; never coincides with rx_valid
rx_err  out  1  qualifies rx_eof; 1 = frame bad
rx_err_code  out  2  qualifies rx_eof: 0 none, 1 CRC, 2 length, 3 alignment
rx_len  out  11  qualifies rx_eof: byte count including FCS, saturates at MAX_FRAME+1

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 0xFFFFFFFF; counters 0.
- Sample enable: every clock when speed_10=0. When speed_10=1, on divider count 0 of a 0..9 counter.
  - In IDLE the counter is held at 0 until CRS_DV is seen high.
  - That first high sample is counted as the first sample.
- Dibit order: LSB first. Byte = {d3,d2,d1,d0}, where d0 is the first dibit received.
- State machine, evaluated on sample enables:
  - IDLE: crs=1 and rxd=01 -> PREAMBLE. Otherwise stay.
  - PREAMBLE: crs=0 -> IDLE, no eof. rxd=01 -> stay. rxd=11 -> DATA, dibit counter cleared. Any other value -> DROP.
  - DATA: shift the dibit in. On the 4th dibit:
    - Pulse rx_valid for one clock, with rx_data = assembled byte.
    - rx_sof=1 if this is the first byte.
    - Update the CRC and increment the length counter.
    - If the new length > MAX_FRAME: stop emitting bytes and go to DROP, remembering a length error.
  - DATA with crs=0: go to END. If the dibit counter was not 0 at that moment, record an alignment error.
  - DROP: discard input until crs=0 -> END. Set a length error if one was recorded; otherwise return to IDLE with no eof (bad preamble).
  - END: one clock.
    - Pulse rx_eof with rx_err, rx_err_code and rx_len.
    - Then go to IDLE and reinitialise the CRC, length and sof flag.
- CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, processed LSB first over every byte including FCS. Good frame: register == 0xDEBB20E3 at END.
- Error priority at END: alignment (3) > length (2; len < MIN_FRAME or len > MAX_FRAME) > CRC (1).
  - rx_err = (rx_err_code != 0).
- Latency: rx_valid is asserted the clock after the 4th dibit of a byte is sampled.
- rx_len, rx_err and rx_err_code hold their values until the next rx_eof. rx_data holds until the next rx_valid.
- crs falling exactly on a byte boundary is normal termination. A crs glitch (low for one sample) in DATA ends the frame.
- Async reset mid-frame: immediate return to the reset state; no eof is emitted for the aborted frame.

Decomposition:
- Package myminimac_pkg holds:
  - CRC32_POLY_REFL = 0xEDB88320, CRC32_INIT = 0xFFFFFFFF, CRC32_RESIDUE = 0xDEBB20E3
  - RMII_PREAMBLE_DIBIT = 2'b01, RMII_SFD_DIBIT = 2'b11
  - the state encoding (IDLE, PREAMBLE, DATA, DROP, END)
  - the rx_err_code constants
- One sub-module: myminimac_crc32_d8. It is combinational: next CRC from the current CRC plus one 8-bit byte, reflected. It is shared with the TX path.

Test Plan:
1. 100M, 7×0x55 + 0xD5, 60 payload bytes + correct FCS -> 64 rx_valid strobes, rx_sof on byte 0 only, rx_data sequence matches, one rx_eof with rx_err=0, code 0, rx_len=64.
2. Same frame with payload byte 10 bit 0 flipped -> 64 bytes delivered, rx_eof with rx_err=1, code 1, rx_len=64.
3. 40-byte frame with correct FCS -> rx_eof, code 2, rx_len=40. A 1600-byte frame -> exactly 1536 rx_valid strobes, rx_eof code 2, rx_len=1537.
4. Good 64-byte frame with crs held one extra dibit (odd dibit count) -> rx_eof code 3. A preamble containing 2'b10 -> no rx_valid and no rx_eof.
5. speed_10=1, each dibit held 10 clocks, frame from test 1 -> identical bytes, rx_valid spaced exactly 40 clocks apart, rx_eof code 0.
6. sys_rst pulsed at byte 20 of a frame -> all outputs 0 immediately and no rx_eof. The following good frame is received with code 0 and rx_len=64.
